// File: rtl/letc_core_stage_writeback_if.sv
// M2 -> W payload types and the M2/W handshake interface.
// Shared by the writeback stage (slave side) and whoever drives it (master side).
package letc_core_stage_writeback_pkg;

   typedef enum logic [1:0] {
      RD_SRC_ALU  = 2'd0,
      RD_SRC_CSR  = 2'd1,
      RD_SRC_MEM  = 2'd2,
      RD_SRC_NONE = 2'd3
   } rd_src_e;

   typedef enum logic [1:0] {
      MEM_OP_NONE  = 2'd0,
      MEM_OP_LOAD  = 2'd1,
      MEM_OP_STORE = 2'd2,
      MEM_OP_AMO   = 2'd3
   } mem_op_e;

   // Encodings follow the RISC-V load funct3 values.
   typedef enum logic [2:0] {
      MEM_SIZE_B  = 3'b000,
      MEM_SIZE_H  = 3'b001,
      MEM_SIZE_W  = 3'b010,
      MEM_SIZE_BU = 3'b100,
      MEM_SIZE_HU = 3'b101
   } mem_size_e;

   typedef struct packed {
      logic [29:0] pc_word;
      rd_src_e     rd_src;
      logic [4:0]  rd_idx;
      logic        rd_we;
      logic        csr_expl_wen;
      logic [11:0] csr_idx;
      logic [31:0] csr_old_val;
      logic [31:0] csr_new_val;
      logic [31:0] alu_result;
      logic [31:0] mem_rdata;
      mem_op_e     mem_op;
      mem_size_e   mem_size;
      logic [31:0] mem_wdata;
   } m2_to_w_s;

endpackage

interface letc_core_stage_writeback_if;
   import letc_core_stage_writeback_pkg::*;

   logic     m2_to_w_valid;
   m2_to_w_s m2_to_w;
   logic     w_ready;

   modport master (output m2_to_w_valid, output m2_to_w, input w_ready);
   modport slave  (input m2_to_w_valid, input m2_to_w, output w_ready);
endinterface

// File: rtl/letc_core_stage_writeback.sv
// LETC core writeback stage: registers the M2 result, formats loads, writes rd/CSRs, retires.
// Optional macro LETC_CORE_W_INSTRET_EN implements the writable instret counter; otherwise instret reads 0.
module letc_core_stage_writeback
   import letc_core_stage_writeback_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   letc_core_stage_writeback_if.slave    m2,
   input  logic                          w_flush,
   input  logic                          w_stall,
   output logic                          rf_wen,
   output logic [4:0]                    rf_widx,
   output logic [31:0]                   rf_wdata,
   output logic                          csr_wen,
   output logic [11:0]                   csr_widx,
   output logic [31:0]                   csr_wdata,
   output logic                          retire,
   output logic [29:0]                   retire_pc_word,
   input  logic                          instret_wen,
   input  logic                          instret_whi,
   input  logic [31:0]                   instret_wdata,
   output logic [INSTRET_W-1:0]          instret
);

   logic        ff_valid;
   m2_to_w_s    ff_in;
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        unused_mem_wdata;

   assign m2.w_ready = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff_valid <= 1'b0;
      end else if (!w_stall) begin
         ff_valid <= m2.m2_to_w_valid;
      end
   end

   // Payload is deliberately not reset; ff_valid qualifies every use of it.
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         ff_in <= m2.m2_to_w;
      end
   end

   assign retire         = ff_valid && !w_flush && !w_stall;
   assign retire_pc_word = ff_in.pc_word;

   // Halfword offset uses off[1] only; misaligned halves trap before reaching here.
   always_comb begin
      off     = ff_in.alu_result[1:0];
      ld_byte = ff_in.mem_rdata[{off, 3'b000} +: 8];
      ld_half = ff_in.mem_rdata[{off[1], 4'b0000} +: 16];
      ld_data = ff_in.mem_rdata;
      if (ff_in.mem_op != MEM_OP_AMO) begin
         case (ff_in.mem_size)
            MEM_SIZE_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_SIZE_BU: ld_data = {24'h0, ld_byte};
            MEM_SIZE_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_SIZE_HU: ld_data = {16'h0, ld_half};
            default:     ld_data = ff_in.mem_rdata;
         endcase
      end
   end

   always_comb begin
      rf_wdata = 32'h0;
      case (ff_in.rd_src)
         RD_SRC_ALU: rf_wdata = ff_in.alu_result;
         RD_SRC_CSR: rf_wdata = ff_in.csr_old_val;
         RD_SRC_MEM: rf_wdata = ld_data;
         default:    rf_wdata = 32'h0;
      endcase
   end

   assign rf_wen    = retire && ff_in.rd_we && (ff_in.rd_idx != 5'd0);
   assign rf_widx   = ff_in.rd_idx;
   assign csr_wen   = retire && ff_in.csr_expl_wen;
   assign csr_widx  = ff_in.csr_idx;
   assign csr_wdata = ff_in.csr_new_val;

   assign unused_mem_wdata = ^ff_in.mem_wdata;

`ifdef LETC_CORE_W_INSTRET_EN
   logic [INSTRET_W-1:0] instret_q;
   logic [63:0]          instret_ext;

   // An explicit CSR write takes priority over the retire increment in the same cycle.
   always_comb begin
      instret_ext = 64'(instret_q);
      if (instret_wen) begin
         if (instret_whi) begin
            instret_ext[63:32] = instret_wdata;
         end else begin
            instret_ext[31:0] = instret_wdata;
         end
      end else if (retire) begin
         instret_ext = instret_ext + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_ext[INSTRET_W-1:0];
      end
   end

   assign instret = instret_q;
`else
   logic unused_instret_inputs;

   assign unused_instret_inputs = ^{instret_wen, instret_whi, instret_wdata};
   assign instret               = '0;
`endif

endmodule
